io_ctrl: RTL and testbench



---
 rtl/io_ctrl.sv | 133 +++++++++++++
 tb/tb_io_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_ctrl.sv
// rtl/io_ctrl.sv - memory-mapped LED/switch/timer I/O peripheral with level interrupt
module io_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int          LED_W      = 16,
   parameter int          SW_W       = 2,
   parameter int          DEB_CYCLES = 1000,
   parameter int          TIMER_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic             ce,
   input  logic             iow,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic [LED_W-1:0] led,
   input  logic [SW_W-1:0]  sw,
   output logic             irq
);
   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0]      DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [TIMER_W-1:0] TMR_ONE  = TIMER_W'(1);

   logic [SW_W-1:0]    sync1, sync2, stable, stable_nxt;
   logic [SW_W-1:0]    edge_flags, edge_clr, irq_en_sw;
   logic [CW-1:0]      deb_cnt     [SW_W];
   logic [CW-1:0]      deb_cnt_nxt [SW_W];
   logic               irq_en_t;
   logic [TIMER_W-1:0] tload, tcnt;
   logic               t_en, t_auto, tflag, expire;
   logic               hit, wr, rd;
   logic [2:0]         idx;
   logic               wr_led, wr_tgl, wr_edge, wr_ien, wr_tload, wr_ctrl;
   logic               unused_bits;

   assign hit      = ce && (addr[31:5] == BASE_ADDR[31:5]);
   assign wr       = hit && iow;
   assign rd       = hit && !iow;
   assign idx      = addr[4:2];
   assign wr_led   = wr && (idx == 3'd0);
   assign wr_tgl   = wr && (idx == 3'd1);
   assign wr_edge  = wr && (idx == 3'd3);
   assign wr_ien   = wr && (idx == 3'd4);
   assign wr_tload = wr && (idx == 3'd5);
   assign wr_ctrl  = wr && (idx == 3'd7);
   assign edge_clr = wr_edge ? wdata[SW_W-1:0] : '0;
   assign expire   = t_en && (tcnt == '0);
   assign unused_bits = ^{addr[1:0], wdata};

   // A bit only flips after DEB_CYCLES consecutive cycles of disagreement
   always_comb begin
      stable_nxt = stable;
      for (int i = 0; i < SW_W; i++) begin
         deb_cnt_nxt[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (deb_cnt[i] == DEB_LAST) stable_nxt[i] = sync2[i];
            else                        deb_cnt_nxt[i] = deb_cnt[i] + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= '0;
         sync2      <= '0;
         stable     <= '0;
         edge_flags <= '0;
         irq_en_sw  <= '0;
         irq_en_t   <= 1'b0;
         tload      <= '0;
         tcnt       <= '0;
         t_en       <= 1'b0;
         t_auto     <= 1'b0;
         tflag      <= 1'b0;
         irq        <= 1'b0;
         led        <= '0;
         for (int i = 0; i < SW_W; i++) deb_cnt[i] <= '0;
      end else begin
         sync1  <= sw;
         sync2  <= sync1;
         stable <= stable_nxt;
         for (int i = 0; i < SW_W; i++) deb_cnt[i] <= deb_cnt_nxt[i];

         // A rise landing with a W1C on the same bit keeps the flag
         edge_flags <= (edge_flags & ~edge_clr) | (stable_nxt & ~stable);

         if (wr_led)      led <= wdata[LED_W-1:0];
         else if (wr_tgl) led <= led ^ wdata[LED_W-1:0];

         if (wr_ien) begin
            irq_en_sw <= wdata[SW_W-1:0];
            irq_en_t  <= wdata[31];
         end

         if (wr_tload) begin
            tload <= wdata[TIMER_W-1:0];
            tcnt  <= wdata[TIMER_W-1:0];
         end else if (t_en) begin
            if (tcnt != '0)  tcnt <= tcnt - TMR_ONE;
            else if (t_auto) tcnt <= tload;
         end

         if (wr_ctrl) begin
            t_en   <= wdata[0];
            t_auto <= wdata[1];
         end else if (expire && !t_auto) begin
            t_en <= 1'b0;
         end

         if (expire)                  tflag <= 1'b1;
         else if (wr_ctrl && wdata[2]) tflag <= 1'b0;

         irq <= (|(edge_flags & irq_en_sw)) | (tflag & irq_en_t);
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (idx)
            3'd0:    rdata = 32'(led);
            3'd2:    rdata = 32'(stable);
            3'd3:    rdata = 32'(edge_flags);
            3'd4:    rdata = 32'(irq_en_sw) | {irq_en_t, 31'b0};
            3'd5:    rdata = 32'(tload);
            3'd6:    rdata = 32'(tcnt);
            3'd7:    rdata = {29'b0, tflag, t_auto, t_en};
            default: rdata = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_io_ctrl.sv
// tb/tb_io_ctrl.sv - self-checking bench for io_ctrl: vector table, corner sequences, random vs model
module tb_io_ctrl;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int DEB = 4;
   localparam int LW  = 16;
   localparam int SW  = 2;
   localparam int TW  = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   addr, wdata, rdata;
   logic          ce, iow;
   logic [LW-1:0] led;
   logic [SW-1:0] sw;
   logic          irq;

   always #5 clk = ~clk;

   io_ctrl #(
      .BASE_ADDR(BASE), .LED_W(LW), .SW_W(SW), .DEB_CYCLES(DEB), .TIMER_W(TW)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .ce(ce), .iow(iow), .wdata(wdata),
      .rdata(rdata), .led(led), .sw(sw), .irq(irq)
   );

   int n_chk;
   int n_pass;

   // Reference model: architectural register state plus a history of sampled switch values
   logic [LW-1:0] m_led;
   logic [SW-1:0] m_stable, m_edge, m_ien;
   logic          m_tien, m_en, m_auto, m_tflag, m_irq;
   logic [TW-1:0] m_tload, m_tcnt;
   logic [SW-1:0] m_hist [$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_led = '0; m_stable = '0; m_edge = '0; m_ien = '0; m_tien = 1'b0;
      m_en = 1'b0; m_auto = 1'b0; m_tflag = 1'b0; m_irq = 1'b0;
      m_tload = '0; m_tcnt = '0;
      m_hist = {};
      repeat (DEB + 2) m_hist.push_back('0);
   endtask

   // Switch sampled at edge k reaches the debouncer at edge k+2; stable flips once the
   // last DEB values it has seen all disagree with it.
   task automatic model_step();
      logic [SW-1:0] nst, n_edge;
      logic [SW-1:0] h;
      logic [TW-1:0] n_tcnt;
      logic          n_en, n_auto, n_tflag, hit, wr, expire, all_diff;
      logic [2:0]    idx;
      nst = m_stable;
      for (int i = 0; i < SW; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            h = m_hist[m_hist.size() - 2 - j];
            if (h[i] == m_stable[i]) all_diff = 1'b0;
         end
         if (all_diff) nst[i] = ~m_stable[i];
      end
      m_hist.push_back(sw);
      if (m_hist.size() > DEB + 4) void'(m_hist.pop_front());

      hit = ce && (addr[31:5] == BASE[31:5]);
      wr  = hit && iow;
      idx = addr[4:2];
      m_irq = (|(m_edge & m_ien)) | (m_tflag & m_tien);

      expire = m_en && (m_tcnt == 0);
      n_tcnt = m_tcnt; n_en = m_en; n_auto = m_auto; n_tflag = m_tflag;
      if (m_en) begin
         if (m_tcnt != 0) n_tcnt = m_tcnt - 1;
         else if (m_auto) n_tcnt = m_tload;
         else n_en = 1'b0;
      end
      n_edge = m_edge;
      if (wr) begin
         case (idx)
            3'd0: m_led = wdata[LW-1:0];
            3'd1: m_led = m_led ^ wdata[LW-1:0];
            3'd3: n_edge = m_edge & ~wdata[SW-1:0];
            3'd4: begin m_ien = wdata[SW-1:0]; m_tien = wdata[31]; end
            3'd5: begin m_tload = wdata; n_tcnt = wdata; end
            3'd7: begin n_en = wdata[0]; n_auto = wdata[1]; if (wdata[2]) n_tflag = 1'b0; end
            default: ;
         endcase
      end
      if (expire) n_tflag = 1'b1;
      n_edge = n_edge | (nst & ~m_stable);
      m_stable = nst; m_edge = n_edge; m_tcnt = n_tcnt;
      m_en = n_en; m_auto = n_auto; m_tflag = n_tflag;
   endtask

   function automatic logic [31:0] model_rd(input logic [2:0] idx);
      case (idx)
         3'd0:    return 32'(m_led);
         3'd2:    return 32'(m_stable);
         3'd3:    return 32'(m_edge);
         3'd4:    return 32'(m_ien) | {m_tien, 31'b0};
         3'd5:    return m_tload;
         3'd6:    return m_tcnt;
         3'd7:    return {29'b0, m_tflag, m_auto, m_en};
         default: return 32'h0;
      endcase
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ce = 1'b1; iow = 1'b1; addr = a; wdata = d;
      cycle();
      ce = 1'b0; iow = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ce = 1'b1; iow = 1'b0; addr = a;
      #1;
      d = rdata;
      ce = 1'b0;
   endtask

   task automatic chk_rd(input string nm, input logic [7:0] off, input logic [31:0] exp);
      logic [31:0] v;
      rd(BASE + 32'(off), v);
      check(nm, v, exp);
   endtask

   typedef struct {
      logic        is_wr;
      logic [7:0]  off;
      logic [31:0] data;
      logic [31:0] exp;   // led after a write, rdata for a read
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs [$];
      logic [31:0] v;
      int          exp_t [4];
      logic [2:0]  ri;
      int unsigned r;

      n_chk = 0; n_pass = 0;
      rst = 1'b0; ce = 1'b0; iow = 1'b0; addr = '0; wdata = '0; sw = 2'b11;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_led", 32'(led), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      for (int i = 0; i < 8; i++) begin
         rd(BASE + 32'(i * 4), v);
         check($sformatf("rst_rd%0d", i), v, 32'h0);
      end
      sw = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b1;

      vecs.push_back('{1'b1, 8'h00, 32'h0000_A5A5, 32'h0000_A5A5});
      vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_A5A5});
      vecs.push_back('{1'b1, 8'h04, 32'h0000_00FF, 32'h0000_A55A});
      vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_A55A});
      vecs.push_back('{1'b1, 8'h00, 32'hFFFF_1234, 32'h0000_1234});
      vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_1234});
      vecs.push_back('{1'b1, 8'h10, 32'h8000_0003, 32'h0000_1234});
      vecs.push_back('{1'b0, 8'h10, 32'h0,         32'h8000_0003});
      vecs.push_back('{1'b1, 8'h10, 32'h0,         32'h0000_1234});
      vecs.push_back('{1'b0, 8'h10, 32'h0,         32'h0});
      vecs.push_back('{1'b1, 8'h14, 32'h0000_0050, 32'h0000_1234});
      vecs.push_back('{1'b0, 8'h14, 32'h0,         32'h0000_0050});
      vecs.push_back('{1'b0, 8'h18, 32'h0,         32'h0000_0050});
      vecs.push_back('{1'b0, 8'h08, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 8'h1C, 32'h0,         32'h0});
      vecs.push_back('{1'b1, 8'h20, 32'h0000_FFFF, 32'h0000_1234});
      vecs.push_back('{1'b0, 8'h20, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 8'h03, 32'h0,         32'h0000_1234});
      foreach (vecs[k]) begin
         if (vecs[k].is_wr) begin
            wr(BASE + 32'(vecs[k].off), vecs[k].data);
            check($sformatf("vec%0d_led", k), 32'(led), vecs[k].exp);
         end else begin
            rd(BASE + 32'(vecs[k].off), v);
            check($sformatf("vec%0d_rd", k), v, vecs[k].exp);
         end
      end

      ce = 1'b0; iow = 1'b1; addr = BASE; wdata = 32'h0000_FFFF;
      cycle();
      iow = 1'b0;
      check("ce0_wr_led", 32'(led), 32'h0000_1234);
      ce = 1'b0; iow = 1'b0; addr = BASE; #1;
      check("ce0_rd", rdata, 32'h0);
      ce = 1'b1; iow = 1'b1; addr = BASE; #1;
      check("wr_cycle_rd", rdata, 32'h0);
      ce = 1'b0; iow = 1'b0;

      // Debounce latency: 2 sync stages + DEB stable cycles
      sw = 2'b01;
      repeat (5) cycle();
      chk_rd("deb_sw_early", 8'h08, 32'h0);
      cycle();
      chk_rd("deb_sw_late", 8'h08, 32'h1);
      chk_rd("deb_edge", 8'h0C, 32'h1);
      check("deb_irq_off", 32'(irq), 32'h0);
      wr(BASE + 32'h0C, 32'h1);
      sw = 2'b00;
      repeat (6) cycle();
      chk_rd("fall_sw", 8'h08, 32'h0);
      chk_rd("fall_no_edge", 8'h0C, 32'h0);
      sw = 2'b01;
      repeat (3) cycle();
      sw = 2'b00;
      repeat (8) cycle();
      chk_rd("pulse_sw", 8'h08, 32'h0);
      chk_rd("pulse_edge", 8'h0C, 32'h0);

      wr(BASE + 32'h10, 32'h1);
      sw = 2'b01;
      repeat (6) cycle();
      chk_rd("eirq_edge", 8'h0C, 32'h1);
      check("eirq_lag", 32'(irq), 32'h0);
      cycle();
      check("eirq_set", 32'(irq), 32'h1);
      wr(BASE + 32'h0C, 32'h1);
      chk_rd("eirq_w1c", 8'h0C, 32'h0);
      cycle();
      check("eirq_clr", 32'(irq), 32'h0);
      sw = 2'b00;
      repeat (6) cycle();
      sw = 2'b01;
      repeat (5) cycle();
      wr(BASE + 32'h0C, 32'h1);
      chk_rd("w1c_vs_set", 8'h0C, 32'h1);
      wr(BASE + 32'h0C, 32'h1);
      wr(BASE + 32'h10, 32'h0);

      wr(BASE + 32'h14, 32'd3);
      wr(BASE + 32'h10, 32'h8000_0000);
      wr(BASE + 32'h1C, 32'h1);
      chk_rd("os_t3", 8'h18, 32'd3);
      cycle(); chk_rd("os_t2", 8'h18, 32'd2);
      cycle(); chk_rd("os_t1", 8'h18, 32'd1);
      cycle(); chk_rd("os_t0", 8'h18, 32'd0);
      chk_rd("os_ctrl_run", 8'h1C, 32'h1);
      cycle();
      chk_rd("os_ctrl_done", 8'h1C, 32'h4);
      check("os_irq_lag", 32'(irq), 32'h0);
      cycle();
      check("os_irq", 32'(irq), 32'h1);
      chk_rd("os_hold0", 8'h18, 32'd0);
      cycle();
      chk_rd("os_hold1", 8'h18, 32'd0);
      wr(BASE + 32'h1C, 32'h4);
      cycle();
      check("os_irq_clr", 32'(irq), 32'h0);

      wr(BASE + 32'h14, 32'd2);
      wr(BASE + 32'h1C, 32'h3);
      exp_t = '{2, 1, 0, 2};
      for (int c = 0; c < 4; c++) begin
         if (c > 0) cycle();
         chk_rd($sformatf("ar_tcnt%0d", c), 8'h18, 32'(exp_t[c]));
         chk_rd($sformatf("ar_ctrl%0d", c), 8'h1C, (c == 3) ? 32'h7 : 32'h3);
      end
      wr(BASE + 32'h1C, 32'h7);
      chk_rd("ar_clr_t", 8'h18, 32'd1);
      chk_rd("ar_clr_c", 8'h1C, 32'h3);
      cycle();
      chk_rd("ar_pre_t", 8'h18, 32'd0);
      wr(BASE + 32'h1C, 32'h7);
      chk_rd("ar_exp_t", 8'h18, 32'd2);
      chk_rd("ar_exp_c", 8'h1C, 32'h7);
      wr(BASE + 32'h1C, 32'h4);
      chk_rd("ar_stop_c", 8'h1C, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) sw = sw ^ 2'($urandom_range(1, 3));
         r = $urandom_range(0, 15);
         if (r < 8) begin
            ri    = 3'($urandom_range(0, 7));
            ce    = (r != 7);
            iow   = 1'b1;
            addr  = BASE + 32'(ri) * 4 + 32'($urandom_range(0, 3)) + ((r == 6) ? 32'h20 : 32'h0);
            wdata = $urandom;
            if (ri == 3'd5) wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
            if (ri == 3'd7) wdata = 32'($urandom_range(0, 7));
         end
         cycle();
         ce = 1'b0; iow = 1'b0;
         check("rnd_led", 32'(led), 32'(m_led));
         check("rnd_irq", 32'(irq), 32'(m_irq));
         ri = 3'($urandom_range(0, 7));
         rd(BASE + 32'(ri) * 4, v);
         check($sformatf("rnd_rd%0d", ri), v, model_rd(ri));
      end

      sw = 2'b00;
      repeat (DEB + 4) cycle();
      wr(BASE + 32'h1C, 32'h4);
      wr(BASE + 32'h0C, 32'h3);
      wr(BASE + 32'h10, 32'h1);
      sw = 2'b01;
      repeat (7) cycle();
      check("pre_rst_irq", 32'(irq), 32'h1);
      sw = 2'b10;
      repeat (3) cycle();
      wr(BASE + 32'h14, 32'h50);
      chk_rd("pre_rst_tcnt", 8'h18, 32'h50);
      #3;
      rst = 1'b0;
      #1;
      check("arst_irq", 32'(irq), 32'h0);
      check("arst_led", 32'(led), 32'h0);
      chk_rd("arst_tcnt", 8'h18, 32'h0);
      chk_rd("arst_sw", 8'h08, 32'h0);
      chk_rd("arst_edge", 8'h0C, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) cycle();
      chk_rd("post_rst_sw_early", 8'h08, 32'h0);
      cycle();
      chk_rd("post_rst_sw", 8'h08, 32'h2);
      chk_rd("post_rst_edge", 8'h0C, 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
